// File: rtl/dram_sp_ctrl.sv
// Single-port RAM controller: clears the RAM after reset, then arbitrates
// one write or one read per cycle with fair alternation under contention.
module dram_sp_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_dvalid,
  output logic          init_done,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_di,
  output logic          ram_wre,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [0:0]    ST_INIT   = 1'b0;
  localparam logic [0:0]    ST_RUN    = 1'b1;
  localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [0:0]    state;
  logic [AW-1:0] counter;
  logic [AW-1:0] ram_ad_q;
  logic          prio_rd;
  logic          in_run;
  logic          contested;

  assign in_run    = (state == ST_RUN);
  assign contested = wr_valid & rd_valid;

  // prio_rd set means the read side wins the next contested cycle
  assign wr_ready = in_run & wr_valid & (~rd_valid | ~prio_rd);
  assign rd_ready = in_run & rd_valid & (~wr_valid | prio_rd);

  always_comb begin
    ram_ad  = ram_ad_q;
    ram_di  = wr_data;
    ram_wre = 1'b0;
    if (!in_run) begin
      ram_ad  = counter;
      ram_di  = '0;
      ram_wre = rst_n;
    end else if (wr_ready) begin
      ram_ad  = wr_addr;
      ram_wre = 1'b1;
    end else if (rd_ready) begin
      ram_ad  = rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      counter   <= '0;
      init_done <= 1'b0;
      prio_rd   <= 1'b0;
      ram_ad_q  <= '0;
      rd_dvalid <= 1'b0;
      rd_data   <= '0;
    end else begin
      ram_ad_q  <= ram_ad;
      rd_dvalid <= rd_ready;
      if (rd_ready) begin
        rd_data <= ram_dout;
      end
      if (state == ST_INIT) begin
        counter <= counter + ADDR_ONE;
        if (counter == ADDR_LAST) begin
          state     <= ST_RUN;
          init_done <= 1'b1;
        end
      end else if (contested) begin
        prio_rd <= ~prio_rd;
      end
    end
  end

endmodule

// File: tb/tb_dram_sp_ctrl.sv
// Directed bench for dram_sp_ctrl with a behavioural async-read RAM16 model.
module tb_dram_sp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, rd_valid;
  logic       wr_ready, rd_ready;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic       rd_dvalid, init_done;
  logic [3:0] ram_ad;
  logic [7:0] ram_di, ram_dout;
  logic       ram_wre;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [16] = '{default: 8'h5A};

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_wre) mem[ram_ad] <= ram_di;
  assign ram_dout = mem[ram_ad];

  dram_sp_ctrl #(.DW(8), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_dvalid(rd_dvalid), .init_done(init_done),
    .ram_ad(ram_ad), .ram_di(ram_di), .ram_wre(ram_wre), .ram_dout(ram_dout)
  );

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1;
    wr_addr = 4'd0; wr_data = 8'h00; rd_addr = 4'd0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_wr_ready got=%0h exp=0", wr_ready); end
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_rd_ready got=%0h exp=0", rd_ready); end
    checks++; if (ram_wre !== 1'b0) begin errors++; $display("[TB] FAIL rst_ram_wre got=%0h exp=0", ram_wre); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_init_done got=%0h exp=0", init_done); end
    checks++; if (rd_dvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rd_dvalid got=%0h exp=0", rd_dvalid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_rd_data got=%0h exp=0", rd_data); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (ram_ad !== 4'(i)) begin errors++; $display("[TB] FAIL clr_ram_ad got=%0h exp=%0h", ram_ad, i); end
      checks++; if (ram_wre !== 1'b1 || ram_di !== 8'h00) begin errors++; $display("[TB] FAIL clr_write wre=%0h di=%0h exp wre=1 di=0", ram_wre, ram_di); end
      checks++; if (wr_ready !== 1'b0 || rd_ready !== 1'b0) begin errors++; $display("[TB] FAIL clr_ready got wr=%0h rd=%0h exp 0 0", wr_ready, rd_ready); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL clr_init_done got=%0h exp=0 at %0d", init_done, i); end
      @(negedge clk);
    end
    wr_valid = 1'b0; rd_valid = 1'b0; #1;
    checks++; if (init_done !== 1'b1) begin errors++; $display("[TB] FAIL init_done_rise got=%0h exp=1", init_done); end
  endtask

  task automatic test_write_read();
    @(negedge clk); wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5; #1;
    checks++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin errors++; $display("[TB] FAIL wr_grant got wr=%0h rd=%0h exp 1 0", wr_ready, rd_ready); end
    checks++; if (ram_wre !== 1'b1 || ram_ad !== 4'd3 || ram_di !== 8'hA5) begin errors++; $display("[TB] FAIL wr_ram got wre=%0h ad=%0h di=%0h exp 1 3 a5", ram_wre, ram_ad, ram_di); end
    @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd3; #1;
    checks++; if (rd_ready !== 1'b1 || ram_wre !== 1'b0 || ram_ad !== 4'd3) begin errors++; $display("[TB] FAIL rd_grant got rdy=%0h wre=%0h ad=%0h exp 1 0 3", rd_ready, ram_wre, ram_ad); end
    checks++; if (rd_dvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_early_dvalid got=%0h exp=0", rd_dvalid); end
    @(negedge clk); rd_valid = 1'b0; #1;
    checks++; if (rd_dvalid !== 1'b1 || rd_data !== 8'hA5) begin errors++; $display("[TB] FAIL raw_data got dv=%0h data=%0h exp 1 a5", rd_dvalid, rd_data); end
    @(negedge clk); #1;
    checks++; if (rd_dvalid !== 1'b0 || rd_data !== 8'hA5) begin errors++; $display("[TB] FAIL rd_hold got dv=%0h data=%0h exp 0 a5", rd_dvalid, rd_data); end
    checks++; if (ram_ad !== 4'd3 || ram_wre !== 1'b0) begin errors++; $display("[TB] FAIL idle_ad_hold got ad=%0h wre=%0h exp 3 0", ram_ad, ram_wre); end
  endtask

  task automatic test_read_unwritten();
    @(negedge clk); rd_valid = 1'b1; rd_addr = 4'd9;
    @(negedge clk); rd_valid = 1'b0; #1;
    checks++; if (rd_dvalid !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("[TB] FAIL rd_cleared got dv=%0h data=%0h exp 1 0", rd_dvalid, rd_data); end
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_grant;
    logic [3:0] exp_dv;
    exp_grant = 4'b1010;
    exp_dv    = 4'b0100;
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 8'h3C;
    rd_valid = 1'b1; rd_addr = 4'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (rd_ready !== exp_grant[i] || wr_ready !== ~exp_grant[i]) begin errors++; $display("[TB] FAIL arb_grant cyc=%0d got wr=%0h rd=%0h exp rd=%0h", i, wr_ready, rd_ready, exp_grant[i]); end
      checks++; if (rd_dvalid !== exp_dv[i]) begin errors++; $display("[TB] FAIL arb_dvalid cyc=%0d got=%0h exp=%0h", i, rd_dvalid, exp_dv[i]); end
      @(negedge clk);
    end
    wr_valid = 1'b0; rd_valid = 1'b0; #1;
    checks++; if (rd_dvalid !== 1'b1 || rd_data !== 8'hA5) begin errors++; $display("[TB] FAIL arb_last_read got dv=%0h data=%0h exp 1 a5", rd_dvalid, rd_data); end
    @(negedge clk);
    wr_valid = 1'b1; rd_valid = 1'b1; #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL arb_prio_restore got wr=%0h exp=1", wr_ready); end
    @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge clk); wr_valid = 1'b1; wr_addr = 4'd15; wr_data = 8'hFF;
    @(negedge clk); wr_addr = 4'd0; wr_data = 8'h01;
    @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd15;
    @(negedge clk); rd_addr = 4'd0; #1;
    checks++; if (rd_dvalid !== 1'b1 || rd_data !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_rd15 got dv=%0h data=%0h exp 1 ff", rd_dvalid, rd_data); end
    @(negedge clk); rd_valid = 1'b0; #1;
    checks++; if (rd_dvalid !== 1'b1 || rd_data !== 8'h01) begin errors++; $display("[TB] FAIL wrap_rd0 got dv=%0h data=%0h exp 1 01", rd_dvalid, rd_data); end
  endtask

  task automatic test_reset_mid_init();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (7) @(negedge clk);
    #1;
    checks++; if (ram_ad !== 4'd7) begin errors++; $display("[TB] FAIL mid_init_ad got=%0h exp=7", ram_ad); end
    rst_n = 1'b0; #1;
    checks++; if (ram_wre !== 1'b0 || init_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_init_rst got wre=%0h done=%0h exp 0 0", ram_wre, init_done); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (ram_ad !== 4'(i) || init_done !== 1'b0) begin errors++; $display("[TB] FAIL reclr got ad=%0h done=%0h exp ad=%0h done=0", ram_ad, init_done, i); end
      @(negedge clk);
    end
    #1;
    checks++; if (init_done !== 1'b1) begin errors++; $display("[TB] FAIL reclr_done got=%0h exp=1", init_done); end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
    @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd3; #1;
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("[TB] FAIL run_rd_grant got=%0h exp=1", rd_ready); end
    #1 rst_n = 1'b0; #1;
    checks++; if (rd_ready !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL run_rst_ready got wr=%0h rd=%0h exp 0 0", wr_ready, rd_ready); end
    @(negedge clk); rd_valid = 1'b0; #1;
    checks++; if (rd_dvalid !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("[TB] FAIL run_rst_dvalid got dv=%0h data=%0h exp 0 0", rd_dvalid, rd_data); end
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
    rd_valid = 1'b1; rd_addr = 4'd3;
    @(negedge clk); rd_valid = 1'b0; #1;
    checks++; if (rd_dvalid !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("[TB] FAIL run_reclr_data got dv=%0h data=%0h exp 1 0", rd_dvalid, rd_data); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_unwritten();
    test_arbitration();
    test_wrap();
    test_reset_mid_init();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_sp_ctrl.md
DRAM_SP_CTRL -- requirements
Module: dram_sp_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, data width of each RAM word.
REQ-002 SHALL have parameter AW, default 4, address width; depth = 2**AW (16, matching one RAM16S bank).
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port wr_valid  input  1  write request.
REQ-006 SHALL have port wr_ready  output  1  write request accepted this cycle.
REQ-007 SHALL have port wr_addr  input  AW  write address.
REQ-008 SHALL have port wr_data  input  DW  write data.
REQ-009 SHALL have port rd_valid  input  1  read request.
REQ-010 SHALL have port rd_ready  output  1  read request accepted this cycle.
REQ-011 SHALL have port rd_addr  input  AW  read address.
REQ-012 SHALL have port rd_data  output  DW  registered read data.
REQ-013 SHALL have port rd_dvalid  output  1  rd_data valid pulse, one cycle.
REQ-014 SHALL have port init_done  output  1  high once post-reset clear is complete.
REQ-015 SHALL have port ram_ad  output  AW  address to the single-port RAM.
REQ-016 SHALL have port ram_di  output  DW  write data to the RAM.
REQ-017 SHALL have port ram_wre  output  1  RAM write enable, sampled by the RAM on clk.
REQ-018 SHALL have port ram_dout  input  DW  RAM asynchronous read data for ram_ad.

Function
REQ-019 SHALL implement states INIT and RUN; reset enters INIT with clear counter = 0.
REQ-020 In INIT, SHALL drive ram_wre=1, ram_di=0, ram_ad=counter, and increment counter each cycle; after counter = 2**AW-1 is written, SHALL go to RUN and set init_done=1.
REQ-021 In INIT, wr_ready=0 and rd_ready=0 regardless of requests; no request is accepted.
REQ-022 In RUN, SHALL grant at most one request per cycle; wr_ready and rd_ready are combinational from the valids and the priority flag, and never both 1.
REQ-023 Only wr_valid=1 -> wr_ready=1; only rd_valid=1 -> rd_ready=1.
REQ-024 Both valid -> grant the class not granted on the previous contested cycle; priority flag resets to "write first" and toggles only on contested grants.
REQ-025 Write grant: ram_ad=wr_addr, ram_di=wr_data, ram_wre=1 in the same cycle; RAM updates on that clk edge.
REQ-026 Read grant: ram_ad=rd_addr, ram_wre=0; on that clk edge rd_data <= ram_dout, and rd_dvalid=1 in the following cycle (latency 1).
REQ-027 No grant: ram_wre=0, ram_ad holds its last value, rd_dvalid=0 next cycle.
REQ-028 rd_dvalid has no backpressure; rd_data holds its value until the next read completes.
REQ-029 Read granted one cycle after a write to the same address SHALL return the new data (no bypass needed; the write commits first).
REQ-030 Addresses wrap naturally at AW bits; no out-of-range condition exists.
REQ-031 Requester SHALL hold valid/addr/data stable until ready; the block does not latch ungranted requests.

Reset
REQ-032 rst_n low SHALL immediately force: state=INIT, counter=0, init_done=0, rd_dvalid=0, rd_data=0, priority=write, wr_ready=0, rd_ready=0.
REQ-033 Reset asserted mid-INIT or mid-RUN SHALL restart the full clear from address 0 after release; a read grant pending in that cycle produces no rd_dvalid.
REQ-034 ram_wre SHALL be 0 while rst_n is low.

Verification
REQ-035 Release reset, hold wr_valid=rd_valid=1 -> ready stays 0 for 16 cycles, ram_wre=1 with ram_ad 0..15, ram_di=0; init_done rises after address 15.
REQ-036 After init, write addr 3 data 0xA5, then read addr 3 next cycle -> rd_dvalid one cycle after read grant, rd_data=0xA5.
REQ-037 After init, read addr 9 without prior write -> rd_data=0x00.
REQ-038 Both valid for 4 consecutive cycles -> grants W,R,W,R; rd_dvalid pulses one cycle after each R.
REQ-039 Assert rst_n low at clear counter 7, release -> clear restarts at ram_ad=0, init_done=0 until 16 further writes.
REQ-040 Write addr 15 data 0xFF, write addr 0 data 0x01, read 15 and 0 -> 0xFF then 0x01 (no wrap aliasing).
